// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-client memory line arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int LINE_WORDS = 4;
  localparam int OFFSET_W   = 2;
  localparam int BYTE_W     = 2;
  localparam int WORD_W     = 32;
  localparam int LINE_W     = LINE_WORDS * WORD_W;

  localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(LINE_WORDS - 1);

  // Word 0 of a line sits in the most significant slice.
  function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                 input logic [OFFSET_W-1:0] beat);
    logic [WORD_W-1:0] w;
    case (beat)
      2'd0:    w = line[127:96];
      2'd1:    w = line[95:64];
      2'd2:    w = line[63:32];
      default: w = line[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_line_arbiter_lat_pipe.sv
// Read-return alignment: carries {valid, beat} through MEM_LAT stages so the
// returned word can be tagged with its beat and the final word recognised.
module lat_pipe #(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_vld,
  input  logic [1:0] issue_beat,
  output logic       capture,
  output logic       last_next,
  output logic       rvalid,
  output logic [1:0] ridx
);
  import mem_arb_pkg::*;

  logic [MEM_LAT-1:0]               vld_p;
  logic [MEM_LAT-1:0][OFFSET_W-1:0] beat_p;
  logic [OFFSET_W-1:0]              cap_beat;

  // Shift the issued-read tag along; an abort by reset drops all in-flight tags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p  <= '0;
      beat_p <= '0;
    end else begin
      vld_p[0]  <= issue_vld;
      beat_p[0] <= issue_beat;
      for (int i = 1; i < MEM_LAT; i++) begin
        vld_p[i]  <= vld_p[i-1];
        beat_p[i] <= beat_p[i-1];
      end
    end
  end

  // The tag about to enter the last stage marks the cycle M_DI must be captured.
  if (MEM_LAT == 1) begin : g_direct
    assign capture  = issue_vld;
    assign cap_beat = issue_beat;
  end else begin : g_staged
    assign capture  = vld_p[MEM_LAT-2];
    assign cap_beat = beat_p[MEM_LAT-2];
  end

  assign last_next = capture && (cap_beat == LAST_BEAT);
  assign rvalid    = vld_p[MEM_LAT-1];
  assign ridx      = beat_p[MEM_LAT-1];

endmodule

// File: rtl/mem_line_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port between the
// instruction-cache (0) and data-cache (1) line refill/write-back engines.
// Each grant runs one full 4-word burst to completion.
module mem_line_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         REQ0,
  input  logic                         REQ1,
  input  logic                         WE0,
  input  logic                         WE1,
  input  logic [ADDR_W-5:0]            LADDR0,
  input  logic [ADDR_W-5:0]            LADDR1,
  input  logic [LINE_WORDS*DATA_W-1:0] WDATA0,
  input  logic [LINE_WORDS*DATA_W-1:0] WDATA1,
  output logic                         GNT0,
  output logic                         GNT1,
  output logic                         RVALID,
  output logic [DATA_W-1:0]            RDATA,
  output logic [1:0]                   RIDX,
  output logic                         DONE0,
  output logic                         DONE1,
  output logic                         BUSY,
  output logic                         M_CSN,
  output logic                         M_WEN,
  output logic [ADDR_W-1:0]            M_ADDR,
  output logic [DATA_W-1:0]            M_DOUT,
  input  logic [DATA_W-1:0]            M_DI
);
  import mem_arb_pkg::*;

  state_t                      state;
  logic [OFFSET_W-1:0]         beat;
  logic [OFFSET_W-1:0]         beat_nxt;
  logic                        last;
  logic                        owner;
  logic                        first_idle;

  logic                        we_l;
  logic [ADDR_W-5:0]           laddr_l;
  logic [LINE_WORDS*DATA_W-1:0] wdata_l;

  logic                        req0_eff;
  logic                        req1_eff;
  logic                        pick_vld;
  logic                        pick;
  logic                        pick_we;
  logic [ADDR_W-5:0]           pick_laddr;
  logic [LINE_WORDS*DATA_W-1:0] pick_wdata;

  logic                        issue_vld;
  logic                        capture;
  logic                        last_next;

  // Arbitration: mask the just-served client for one IDLE cycle so a
  // registered REQ drop is not mistaken for a new request, then round-robin.
  always_comb begin
    req0_eff   = REQ0 && !(first_idle && (last == 1'b0));
    req1_eff   = REQ1 && !(first_idle && (last == 1'b1));
    pick_vld   = req0_eff || req1_eff;
    pick       = (req0_eff && req1_eff) ? ~last : req1_eff;
    pick_we    = pick ? WE1 : WE0;
    pick_laddr = pick ? LADDR1 : LADDR0;
    pick_wdata = pick ? WDATA1 : WDATA0;
    beat_nxt   = beat + 2'd1;
  end

  // Latch the winner's request so later changes on the inputs are ignored.
  always_ff @(posedge CLK) begin
    if ((state == IDLE) && pick_vld) begin
      we_l    <= pick_we;
      laddr_l <= pick_laddr;
      wdata_l <= pick_wdata;
    end
  end

  // Burst sequencer with registered grant, completion and memory-port outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      beat       <= '0;
      last       <= 1'b1;
      owner      <= 1'b0;
      first_idle <= 1'b0;
      GNT0       <= 1'b0;
      GNT1       <= 1'b0;
      DONE0      <= 1'b0;
      DONE1      <= 1'b0;
      BUSY       <= 1'b0;
      M_CSN      <= 1'b1;
      M_WEN      <= 1'b1;
      M_ADDR     <= '0;
      M_DOUT     <= '0;
    end else begin
      DONE0 <= 1'b0;
      DONE1 <= 1'b0;
      case (state)
        IDLE: begin
          first_idle <= 1'b0;
          if (pick_vld) begin
            state  <= XFER;
            beat   <= '0;
            last   <= pick;
            owner  <= pick;
            GNT0   <= ~pick;
            GNT1   <= pick;
            BUSY   <= 1'b1;
            M_CSN  <= 1'b0;
            M_WEN  <= ~pick_we;
            M_ADDR <= {pick_laddr, {OFFSET_W{1'b0}}, {BYTE_W{1'b0}}};
            M_DOUT <= pick_we ? word_sel(pick_wdata, {OFFSET_W{1'b0}}) : '0;
          end
        end
        XFER: begin
          if (beat == LAST_BEAT) begin
            M_CSN  <= 1'b1;
            M_WEN  <= 1'b1;
            M_ADDR <= '0;
            M_DOUT <= '0;
            // A read whose final word lands next cycle skips DRAIN.
            if (we_l || last_next) begin
              state <= DONE;
              DONE0 <= ~owner;
              DONE1 <= owner;
            end else begin
              state <= DRAIN;
            end
          end else begin
            beat   <= beat_nxt;
            M_ADDR <= {laddr_l, beat_nxt, {BYTE_W{1'b0}}};
            M_DOUT <= we_l ? word_sel(wdata_l, beat_nxt) : '0;
          end
        end
        DRAIN: begin
          if (last_next) begin
            state <= DONE;
            DONE0 <= ~owner;
            DONE1 <= owner;
          end
        end
        DONE: begin
          state      <= IDLE;
          first_idle <= 1'b1;
          GNT0       <= 1'b0;
          GNT1       <= 1'b0;
          BUSY       <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign issue_vld = (state == XFER) && !we_l;

  lat_pipe #(
    .MEM_LAT(MEM_LAT)
  ) u_lat_pipe (
    .clk       (CLK),
    .rst       (RST),
    .issue_vld (issue_vld),
    .issue_beat(beat),
    .capture   (capture),
    .last_next (last_next),
    .rvalid    (RVALID),
    .ridx      (RIDX)
  );

  // Register the returning word in the cycle its tag reaches the last stage.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RDATA <= '0;
    end else if (capture) begin
      RDATA <= M_DI;
    end
  end

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Directed bench: one arbiter with MEM_LAT=1 (suffix _a) and one with
// MEM_LAT=3 (suffix _b) share the request inputs; each has its own memory.
module tb_mem_line_arbiter;

  logic         clk;
  logic         rst;
  logic         req0, req1, we0, we1;
  logic [7:0]   laddr0, laddr1;
  logic [127:0] wdata0, wdata1;

  logic         gnt0_a, gnt1_a, rvalid_a, done0_a, done1_a, busy_a, m_csn_a, m_wen_a;
  logic [31:0]  rdata_a, m_dout_a, m_di_a;
  logic [1:0]   ridx_a;
  logic [11:0]  m_addr_a;

  logic         gnt0_b, gnt1_b, rvalid_b, done0_b, done1_b, busy_b, m_csn_b, m_wen_b;
  logic [31:0]  rdata_b, m_dout_b, m_di_b;
  logic [1:0]   ridx_b;
  logic [11:0]  m_addr_b;
  logic [11:0]  a1_b, a2_b;

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] mem_word(input logic [11:0] a);
    return 32'hA500_0000 | {20'h0, a};
  endfunction

  mem_line_arbiter #(.MEM_LAT(1)) dut_a (
    .CLK(clk), .RST(rst), .REQ0(req0), .REQ1(req1), .WE0(we0), .WE1(we1),
    .LADDR0(laddr0), .LADDR1(laddr1), .WDATA0(wdata0), .WDATA1(wdata1),
    .GNT0(gnt0_a), .GNT1(gnt1_a), .RVALID(rvalid_a), .RDATA(rdata_a), .RIDX(ridx_a),
    .DONE0(done0_a), .DONE1(done1_a), .BUSY(busy_a), .M_CSN(m_csn_a), .M_WEN(m_wen_a),
    .M_ADDR(m_addr_a), .M_DOUT(m_dout_a), .M_DI(m_di_a)
  );

  mem_line_arbiter #(.MEM_LAT(3)) dut_b (
    .CLK(clk), .RST(rst), .REQ0(req0), .REQ1(req1), .WE0(we0), .WE1(we1),
    .LADDR0(laddr0), .LADDR1(laddr1), .WDATA0(wdata0), .WDATA1(wdata1),
    .GNT0(gnt0_b), .GNT1(gnt1_b), .RVALID(rvalid_b), .RDATA(rdata_b), .RIDX(ridx_b),
    .DONE0(done0_b), .DONE1(done1_b), .BUSY(busy_b), .M_CSN(m_csn_b), .M_WEN(m_wen_b),
    .M_ADDR(m_addr_b), .M_DOUT(m_dout_b), .M_DI(m_di_b)
  );

  // Memory models: the word for an address issued in cycle t must be on M_DI
  // in cycle t+MEM_LAT-1 so the arbiter's capture register shows it at t+MEM_LAT.
  assign m_di_a = mem_word(m_addr_a);

  always_ff @(posedge clk) begin
    a1_b <= m_addr_b;
    a2_b <= a1_b;
  end
  assign m_di_b = mem_word(a2_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req0 = 1'b0;
    req1 = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    checks++; if ({gnt0_a, gnt1_a} !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b exp=00", {gnt0_a, gnt1_a}); end
    checks++; if ({rvalid_a, done0_a, done1_a, busy_a} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl got=%b exp=0000", {rvalid_a, done0_a, done1_a, busy_a}); end
    checks++; if ({m_csn_a, m_wen_a} !== 2'b11) begin errors++; $display("FAIL reset_mem_ctl got=%b exp=11", {m_csn_a, m_wen_a}); end
    checks++; if (m_addr_a !== 12'h000) begin errors++; $display("FAIL reset_maddr got=%h exp=000", m_addr_a); end
    checks++; if (m_dout_a !== 32'h0) begin errors++; $display("FAIL reset_mdout got=%h exp=0", m_dout_a); end
    checks++; if ({rdata_a, ridx_a} !== 34'h0) begin errors++; $display("FAIL reset_rdata got=%h/%0d exp=0/0", rdata_a, ridx_a); end
    checks++; if ({busy_b, gnt0_b, gnt1_b, m_csn_b} !== 4'b0001) begin errors++; $display("FAIL reset_b got=%b exp=0001", {busy_b, gnt0_b, gnt1_b, m_csn_b}); end
    rst = 1'b0;
    idle(3);
  endtask

  task automatic test_single_read();
    logic [11:0] a;
    req0 = 1'b1; we0 = 1'b0; laddr0 = 8'h12;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k <= 4) begin
        a = 12'h120 + 12'(4 * (k - 1));
        checks++; if ({gnt0_a, gnt1_a, m_csn_a, m_wen_a} !== 4'b1001) begin errors++; $display("FAIL rd_ctl k=%0d got=%b exp=1001", k, {gnt0_a, gnt1_a, m_csn_a, m_wen_a}); end
        checks++; if (m_addr_a !== a) begin errors++; $display("FAIL rd_addr k=%0d got=%h exp=%h", k, m_addr_a, a); end
      end else begin
        checks++; if ({gnt0_a, m_csn_a, m_addr_a} !== {2'b11, 12'h000}) begin errors++; $display("FAIL rd_done_port got=%b/%h exp=11/000", {gnt0_a, m_csn_a}, m_addr_a); end
      end
      if (k >= 2) begin
        a = 12'h120 + 12'(4 * (k - 2));
        checks++; if ({rvalid_a, ridx_a, rdata_a} !== {1'b1, 2'(k - 2), mem_word(a)}) begin errors++; $display("FAIL rd_ret k=%0d got=%b/%0d/%h exp=1/%0d/%h", k, rvalid_a, ridx_a, rdata_a, k - 2, mem_word(a)); end
      end else begin
        checks++; if (rvalid_a !== 1'b0) begin errors++; $display("FAIL rd_rvalid_early got=%b exp=0", rvalid_a); end
      end
      checks++; if (done0_a !== (k == 5)) begin errors++; $display("FAIL rd_done0 k=%0d got=%b exp=%b", k, done0_a, (k == 5)); end
    end
    req0 = 1'b0;
    step();
    checks++; if ({gnt0_a, busy_a, done0_a} !== 3'b000) begin errors++; $display("FAIL rd_idle got=%b exp=000", {gnt0_a, busy_a, done0_a}); end
    idle(10);
  endtask

  task automatic test_single_write();
    logic [31:0] w [4];
    w[0] = 32'hAAAA_0001; w[1] = 32'hBBBB_0002; w[2] = 32'hCCCC_0003; w[3] = 32'hDDDD_0004;
    req1 = 1'b1; we1 = 1'b1; laddr1 = 8'h03; wdata1 = {w[0], w[1], w[2], w[3]};
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k <= 4) begin
        checks++; if ({gnt0_a, gnt1_a, m_csn_a, m_wen_a} !== 4'b0100) begin errors++; $display("FAIL wr_ctl k=%0d got=%b exp=0100", k, {gnt0_a, gnt1_a, m_csn_a, m_wen_a}); end
        checks++; if (m_addr_a !== 12'h030 + 12'(4 * (k - 1))) begin errors++; $display("FAIL wr_addr k=%0d got=%h exp=%h", k, m_addr_a, 12'h030 + 12'(4 * (k - 1))); end
        checks++; if (m_dout_a !== w[k-1]) begin errors++; $display("FAIL wr_dout k=%0d got=%h exp=%h", k, m_dout_a, w[k-1]); end
      end else begin
        checks++; if ({m_wen_a, m_csn_a, m_addr_a, m_dout_a} !== {2'b11, 12'h000, 32'h0}) begin errors++; $display("FAIL wr_done_port got=%b/%h/%h exp=11/000/0", {m_wen_a, m_csn_a}, m_addr_a, m_dout_a); end
        checks++; if (done1_b !== 1'b1) begin errors++; $display("FAIL wr_done1_lat3 got=%b exp=1", done1_b); end
      end
      checks++; if (rvalid_a !== 1'b0) begin errors++; $display("FAIL wr_rvalid k=%0d got=%b exp=0", k, rvalid_a); end
      checks++; if ({done1_a, done0_a} !== {(k == 5), 1'b0}) begin errors++; $display("FAIL wr_done k=%0d got=%b exp=%b0", k, {done1_a, done0_a}, (k == 5)); end
      if (k == 1) begin
        wdata1 = '0;
        we1 = 1'b0;
      end
    end
    req1 = 1'b0;
    idle(10);
  endtask

  task automatic test_reset_mid_burst();
    req0 = 1'b1; we0 = 1'b0; laddr0 = 8'h22;
    step(); step(); step();
    checks++; if (m_addr_a !== 12'h228) begin errors++; $display("FAIL rst_mid_pre got=%h exp=228", m_addr_a); end
    rst = 1'b1;
    #1;
    checks++; if ({gnt0_a, gnt1_a, busy_a, rvalid_a, done0_a} !== 5'b00000) begin errors++; $display("FAIL rst_mid_ctrl got=%b exp=00000", {gnt0_a, gnt1_a, busy_a, rvalid_a, done0_a}); end
    checks++; if ({m_csn_a, m_wen_a, m_addr_a, m_dout_a} !== {2'b11, 12'h000, 32'h0}) begin errors++; $display("FAIL rst_mid_port got=%b/%h/%h exp=11/000/0", {m_csn_a, m_wen_a}, m_addr_a, m_dout_a); end
    checks++; if ({rdata_a, ridx_a} !== 34'h0) begin errors++; $display("FAIL rst_mid_rdata got=%h/%0d exp=0/0", rdata_a, ridx_a); end
    @(posedge clk);
    #1;
    checks++; if ({done0_a, gnt0_a} !== 2'b00) begin errors++; $display("FAIL rst_mid_hold got=%b exp=00", {done0_a, gnt0_a}); end
    rst = 1'b0;
    step();
    checks++; if ({gnt0_a, m_addr_a} !== {1'b1, 12'h220}) begin errors++; $display("FAIL rst_regrant got=%b/%h exp=1/220", gnt0_a, m_addr_a); end
    for (int k = 2; k <= 5; k++) begin
      step();
      checks++; if (done0_a !== (k == 5)) begin errors++; $display("FAIL rst_retry_done k=%0d got=%b exp=%b", k, done0_a, (k == 5)); end
    end
    req0 = 1'b0;
    idle(10);
  endtask

  task automatic test_latched_inputs();
    req0 = 1'b1; we0 = 1'b0; laddr0 = 8'h34;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k <= 4) begin
        checks++; if ({gnt0_a, m_wen_a, m_addr_a} !== {2'b11, 12'h340 + 12'(4 * (k - 1))}) begin errors++; $display("FAIL latch_addr k=%0d got=%b/%h exp=11/%h", k, {gnt0_a, m_wen_a}, m_addr_a, 12'h340 + 12'(4 * (k - 1))); end
      end
      if (k == 2) begin
        req0 = 1'b0; laddr0 = 8'hFF; we0 = 1'b1;
      end
    end
    checks++; if ({done0_a, rvalid_a, ridx_a, rdata_a} !== {2'b11, 2'd3, mem_word(12'h34C)}) begin errors++; $display("FAIL latch_done got=%b%b/%0d/%h exp=11/3/%h", done0_a, rvalid_a, ridx_a, rdata_a, mem_word(12'h34C)); end
    step(); step();
    checks++; if ({gnt0_a, busy_a} !== 2'b00) begin errors++; $display("FAIL latch_no_regrant got=%b exp=00", {gnt0_a, busy_a}); end
    req0 = 1'b1; we0 = 1'b0; laddr0 = 8'hFF;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) begin
        checks++; if (m_addr_a !== 12'hFF0) begin errors++; $display("FAIL wrap_first got=%h exp=FF0", m_addr_a); end
      end
      if (k == 4) begin
        checks++; if (m_addr_a !== 12'hFFC) begin errors++; $display("FAIL wrap_last got=%h exp=FFC", m_addr_a); end
      end
    end
    checks++; if ({done0_a, rdata_a} !== {1'b1, 32'hA500_0FFC}) begin errors++; $display("FAIL wrap_data got=%b/%h exp=1/A5000FFC", done0_a, rdata_a); end
    req0 = 1'b0;
    idle(10);
  endtask

  task automatic test_lat3_read();
    logic [11:0] a;
    req0 = 1'b1; we0 = 1'b0; laddr0 = 8'h40;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k <= 4) begin
        checks++; if ({gnt0_b, m_csn_b, m_addr_b} !== {2'b10, 12'h400 + 12'(4 * (k - 1))}) begin errors++; $display("FAIL l3_addr k=%0d got=%b/%h exp=10/%h", k, {gnt0_b, m_csn_b}, m_addr_b, 12'h400 + 12'(4 * (k - 1))); end
      end
      if (k == 5 || k == 6) begin
        checks++; if ({gnt0_b, busy_b, m_csn_b, m_wen_b, done0_b} !== 5'b11110) begin errors++; $display("FAIL l3_drain k=%0d got=%b exp=11110", k, {gnt0_b, busy_b, m_csn_b, m_wen_b, done0_b}); end
      end
      if (k >= 4 && k <= 7) begin
        a = 12'h400 + 12'(4 * (k - 4));
        checks++; if ({rvalid_b, ridx_b, rdata_b} !== {1'b1, 2'(k - 4), mem_word(a)}) begin errors++; $display("FAIL l3_ret k=%0d got=%b/%0d/%h exp=1/%0d/%h", k, rvalid_b, ridx_b, rdata_b, k - 4, mem_word(a)); end
      end else if (k < 4) begin
        checks++; if (rvalid_b !== 1'b0) begin errors++; $display("FAIL l3_rvalid_early k=%0d got=%b exp=0", k, rvalid_b); end
      end
      if (k <= 8) begin
        checks++; if (done0_b !== (k == 7)) begin errors++; $display("FAIL l3_done0 k=%0d got=%b exp=%b", k, done0_b, (k == 7)); end
      end
      if (k == 8) begin
        checks++; if ({gnt0_b, gnt1_b, busy_b} !== 3'b000) begin errors++; $display("FAIL l3_idle got=%b exp=000", {gnt0_b, gnt1_b, busy_b}); end
      end
      if (k == 9) begin
        checks++; if ({gnt0_b, gnt1_b, m_addr_b} !== {2'b01, 12'h500}) begin errors++; $display("FAIL l3_next_grant got=%b/%h exp=01/500", {gnt0_b, gnt1_b}, m_addr_b); end
      end
      if (k == 2) begin
        req1 = 1'b1; we1 = 1'b0; laddr1 = 8'h50;
      end
      if (k == 7) req0 = 1'b0;
    end
    req1 = 1'b0;
    idle(14);
  endtask

  task automatic test_round_robin();
    int   n_gnt;
    int   order [8];
    logic prev0, prev1;
    for (int i = 0; i < 8; i++) order[i] = -1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; laddr0 = 8'h10; laddr1 = 8'h20;
    prev0 = 1'b0; prev1 = 1'b0; n_gnt = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      checks++; if (gnt0_a && gnt1_a) begin errors++; $display("FAIL rr_overlap c=%0d got=11 exp=one-hot", c); end
      if (gnt0_a && !prev0) begin if (n_gnt < 8) order[n_gnt] = 0; n_gnt++; end
      if (gnt1_a && !prev1) begin if (n_gnt < 8) order[n_gnt] = 1; n_gnt++; end
      prev0 = gnt0_a;
      prev1 = gnt1_a;
    end
    checks++; if (n_gnt < 4) begin errors++; $display("FAIL rr_count got=%0d exp>=4", n_gnt); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (order[i] != (i % 2)) begin errors++; $display("FAIL rr_order i=%0d got=%0d exp=%0d", i, order[i], i % 2); end
    end
    idle(12);
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    laddr0 = '0; laddr1 = '0; wdata0 = '0; wdata1 = '0;
    test_reset();
    test_single_read();
    test_single_write();
    test_reset_mid_burst();
    test_latched_inputs();
    test_lat3_read();
    test_round_robin();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
